// File: rtl/if_id_queue.sv
// if_id_queue: IF->ID decoupling buffer, DEPTH-entry circular queue.
// Holds {pc, pc_plus4, instr}; flush drops all; in_ready feeds ~stall_if.
// Ports: clk, rst (async, active-low), flush,
//   in_valid/in_ready/in_pc/in_pc_plus4/in_instr (from IF),
//   out_valid/out_ready/out_pc/out_pc_plus4/out_instr (to ID), count.
// Option: define IF_ID_BYPASS_EN for a 0-cycle path when empty.
module if_id_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_pc_plus4,
  input  logic [31:0]              in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_pc_plus4,
  output logic [31:0]              out_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } ent_t;

  ent_t          mem [DEPTH];
  ent_t          in_ent;
  ent_t          head;
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [CW-1:0] cnt;
  logic          empty;
  logic          byp;
  logic          push;
  logic          pop;

  assign in_ent = '{pc: in_pc, pc_plus4: in_pc_plus4, instr: in_instr};
  assign empty  = (cnt == '0);

`ifdef IF_ID_BYPASS_EN
  assign byp = empty && in_valid && !flush;
`else
  assign byp = 1'b0;
`endif

  assign in_ready  = (cnt != CW'(DEPTH));
  assign out_valid = !empty || byp;
  assign count     = cnt;

  // A bypassed entry taken by ID this cycle is never written.
  assign push = in_valid && in_ready && !flush
             && !(byp && out_ready);
  assign pop  = !empty && out_ready && !flush;

  assign head = byp ? in_ent : mem[rptr];

  always_comb begin
    out_pc       = '0;
    out_pc_plus4 = '0;
    out_instr    = NOP_INSTR;
    if (out_valid) begin
      out_pc       = head.pc;
      out_pc_plus4 = head.pc_plus4;
      out_instr    = head.instr;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= in_ent;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      unique case (1'b1)
        push && !pop: cnt <= cnt + CW'(1);
        pop && !push: cnt <= cnt - CW'(1);
        default:      cnt <= cnt;
      endcase
    end
  end

endmodule
